alu_seq: RTL and testbench

Parametrised, registered ALU for the datapath core. It keeps the existing operand-select scheme: ALUSRC=0 is register–register, and ALUSRC=1 is an immediate-style op on IN1 chosen by IN3. It adds subtraction, AND, and an iterative unsigned multiply. It also adds a START/BUSY/DONE handshake, registered results and status flags, so the control FSM can sequence multi-cycle operations.

---
 rtl/alu_seq.sv | 201 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a START/BUSY/DONE handshake.
// Single-cycle ops (add, sub, and, immediate pass/inc/dec/-2) complete one
// cycle after START. Unsigned multiply runs as an iterative shift-add, one
// multiplier bit per cycle, and completes WIDTH+1 cycles after START.
// OUT, OUT_HI and the flags hold their values between completions.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             START,
    input  logic             ALUSRC,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] IN1,
    input  logic [WIDTH-1:0] IN2,
    input  logic [1:0]       IN3,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] OUT,
    output logic [WIDTH-1:0] OUT_HI,
    output logic             ZERO,
    output logic             CARRY,
    output logic             OVF
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_AND = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IMM_PASS = 2'b00,
        IMM_INC  = 2'b01,
        IMM_SUB2 = 2'b10,
        IMM_DEC  = 2'b11
    } imm_t;

    state_t           state;

    // Multiply working registers: acc is the running high half, mplr shifts
    // the multiplier out at the bottom while product low bits shift in at the top.
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplr;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;

    // Single-cycle datapath signals
    op_t              op_dec;
    imm_t             imm_dec;
    logic             is_mul;
    logic             do_arith;
    logic             do_sub;
    logic [WIDTH:0]   opa;
    logic [WIDTH:0]   opb;
    logic [WIDTH:0]   sum;
    logic             opb_sign;
    logic [WIDTH:0]   sc_res;
    logic             sc_carry;
    logic             sc_ovf;

    // Multiply step signals
    logic [WIDTH:0]   step_sum;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;

    // Decode the request and compute the single-cycle result and flags from live inputs
    always_comb begin
        op_dec   = op_t'(OP);
        imm_dec  = imm_t'(IN3);
        is_mul   = !ALUSRC && (op_dec == OP_MUL);
        do_arith = 1'b0;
        do_sub   = 1'b0;
        opa      = {1'b0, IN1};
        opb      = '0;
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sum      = '0;
        opb_sign = 1'b0;

        if (ALUSRC) begin
            case (imm_dec)
                IMM_PASS: sc_res = {1'b0, IN1};
                IMM_INC: begin
                    do_arith = 1'b1;
                    opb      = (WIDTH + 1)'(1);
                end
                IMM_SUB2: begin
                    do_arith = 1'b1;
                    do_sub   = 1'b1;
                    opb      = (WIDTH + 1)'(2);
                end
                IMM_DEC: begin
                    do_arith = 1'b1;
                    do_sub   = 1'b1;
                    opb      = (WIDTH + 1)'(1);
                end
                default: sc_res = '0;
            endcase
        end else begin
            case (op_dec)
                OP_ADD: begin
                    do_arith = 1'b1;
                    opb      = {1'b0, IN2};
                end
                OP_SUB: begin
                    do_arith = 1'b1;
                    do_sub   = 1'b1;
                    opb      = {1'b0, IN2};
                end
                OP_AND:  sc_res = {1'b0, IN1 & IN2};
                default: sc_res = '0;
            endcase
        end

        if (do_arith) begin
            sum      = do_sub ? (opa - opb) : (opa + opb);
            sc_res   = sum;
            // Bit WIDTH is the carry for add and the borrow (subtrahend > IN1) for sub
            sc_carry = sum[WIDTH];
            // For subtraction the effective second operand is -opb, whose sign is ~opb's
            opb_sign = do_sub ? ~opb[WIDTH-1] : opb[WIDTH-1];
            sc_ovf   = (opa[WIDTH-1] == opb_sign) && (sum[WIDTH-1] != opa[WIDTH-1]);
        end
    end

    // One shift-add iteration: add multiplicand if the current multiplier bit is set, shift right
    always_comb begin
        step_sum = {1'b0, acc} + (mplr[0] ? {1'b0, mcand} : '0);
        mul_hi   = step_sum[WIDTH:1];
        mul_lo   = {step_sum[0], mplr[WIDTH-1:1]};
    end

    // Control FSM with registered results, flags and handshake outputs
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state  <= IDLE;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            OUT    <= '0;
            OUT_HI <= '0;
            ZERO   <= 1'b1;
            CARRY  <= 1'b0;
            OVF    <= 1'b0;
            mcand  <= '0;
            mplr   <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        if (is_mul) begin
                            mcand <= IN1;
                            mplr  <= IN2;
                            acc   <= '0;
                            cnt   <= '0;
                            BUSY  <= 1'b1;
                            state <= MUL;
                        end else begin
                            OUT    <= sc_res[WIDTH-1:0];
                            OUT_HI <= '0;
                            ZERO   <= (sc_res[WIDTH-1:0] == '0);
                            CARRY  <= sc_carry;
                            OVF    <= sc_ovf;
                            DONE   <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc  <= mul_hi;
                    mplr <= mul_lo;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        OUT    <= mul_lo;
                        OUT_HI <= mul_hi;
                        ZERO   <= (mul_lo == '0);
                        CARRY  <= 1'b0;
                        OVF    <= (mul_hi != '0);
                        DONE   <= 1'b1;
                        BUSY   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): expected results are queued when a
// request is issued and checked against the DUT when DONE pulses.
module tb_alu_seq;

    logic       clk;
    logic       rstn;
    logic       start;
    logic       alusrc;
    logic [1:0] op;
    logic [7:0] in1;
    logic [7:0] in2;
    logic [1:0] in3;
    logic       busy;
    logic       done;
    logic [7:0] out;
    logic [7:0] out_hi;
    logic       zero;
    logic       carry;
    logic       ovf;

    int total = 0;
    int bad   = 0;
    int nb;
    int nt;

    typedef struct {
        string      tag;
        logic [7:0] o;
        logic [7:0] h;
        logic       z;
        logic       c;
        logic       v;
    } exp_t;

    exp_t sb[$];

    alu_seq #(.WIDTH(8)) dut (
        .CLK    (clk),
        .RSTN   (rstn),
        .START  (start),
        .ALUSRC (alusrc),
        .OP     (op),
        .IN1    (in1),
        .IN2    (in2),
        .IN3    (in3),
        .BUSY   (busy),
        .DONE   (done),
        .OUT    (out),
        .OUT_HI (out_hi),
        .ZERO   (zero),
        .CARRY  (carry),
        .OVF    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock edge, sample 1ns later, and retire a scoreboard entry on DONE
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {31'b0, done}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk({e.tag, ".out"},   {24'b0, out},    {24'b0, e.o});
                chk({e.tag, ".hi"},    {24'b0, out_hi}, {24'b0, e.h});
                chk({e.tag, ".zero"},  {31'b0, zero},   {31'b0, e.z});
                chk({e.tag, ".carry"}, {31'b0, carry},  {31'b0, e.c});
                chk({e.tag, ".ovf"},   {31'b0, ovf},    {31'b0, e.v});
            end
        end
    endtask

    task automatic push(input string tag, input logic [7:0] o, input logic [7:0] h,
                        input logic z, input logic c, input logic v);
        exp_t e;
        e.tag = tag; e.o = o; e.h = h; e.z = z; e.c = c; e.v = v;
        sb.push_back(e);
    endtask

    // Drive one request for a single edge; START drops afterwards
    task automatic drive(input logic s, input logic [1:0] o, input logic [7:0] a,
                         input logic [7:0] b, input logic [1:0] i3);
        alusrc = s; op = o; in1 = a; in2 = b; in3 = i3;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Single-cycle request: DONE and result must appear right after the sampling edge
    task automatic single(input string tag, input logic s, input logic [1:0] o,
                          input logic [7:0] a, input logic [7:0] b, input logic [1:0] i3,
                          input logic [7:0] eo, input logic ez, input logic ec, input logic ev);
        push(tag, eo, 8'h00, ez, ec, ev);
        drive(s, o, a, b, i3);
        chk({tag, ".done"}, {31'b0, done}, 32'd1);
        chk({tag, ".retired"}, sb.size(), 32'd0);
    endtask

    task automatic wait_done(output int busy_cycles, output int ticks);
        busy_cycles = 0;
        ticks = 0;
        while (ticks < 40) begin
            if (busy === 1'b1) busy_cycles++;
            tick();
            ticks++;
            if (done === 1'b1) break;
        end
        chk("done_seen", {31'b0, done}, 32'd1);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; alusrc = 1'b0; op = 2'b00;
        in1 = 8'h00; in2 = 8'h00; in3 = 2'b00;

        // Reset state
        tick();
        tick();
        chk("rst.busy",  {31'b0, busy},   32'd0);
        chk("rst.done",  {31'b0, done},   32'd0);
        chk("rst.out",   {24'b0, out},    32'd0);
        chk("rst.hi",    {24'b0, out_hi}, 32'd0);
        chk("rst.zero",  {31'b0, zero},   32'd1);
        chk("rst.carry", {31'b0, carry},  32'd0);
        chk("rst.ovf",   {31'b0, ovf},    32'd0);
        rstn = 1'b1;
        tick();

        // Single-cycle ops; back-to-back requests give DONE every cycle
        single("add_ff_01", 1'b0, 2'b00, 8'hFF, 8'h01, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0);
        tick();
        chk("add.done_low", {31'b0, done}, 32'd0);
        single("sub_80_01", 1'b0, 2'b01, 8'h80, 8'h01, 2'b00, 8'h7F, 1'b0, 1'b0, 1'b1);
        single("sub_01_02", 1'b0, 2'b01, 8'h01, 8'h02, 2'b00, 8'hFF, 1'b0, 1'b1, 1'b0);
        single("imm_m2_01", 1'b1, 2'b10, 8'h01, 8'hAA, 2'b10, 8'hFF, 1'b0, 1'b1, 1'b0);
        single("imm_inc_7f", 1'b1, 2'b00, 8'h7F, 8'h55, 2'b01, 8'h80, 1'b0, 1'b0, 1'b1);
        single("imm_pass_00", 1'b1, 2'b01, 8'h00, 8'hAA, 2'b00, 8'h00, 1'b1, 1'b0, 1'b0);
        single("imm_dec_00", 1'b1, 2'b11, 8'h00, 8'h33, 2'b11, 8'hFF, 1'b0, 1'b1, 1'b0);
        single("and_f0_3c", 1'b0, 2'b11, 8'hF0, 8'h3C, 2'b00, 8'h30, 1'b0, 1'b0, 1'b0);
        tick();

        // Multiply, small product: BUSY for WIDTH cycles, DONE WIDTH edges after the request edge
        push("mul_0f_11", 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 2'b10, 8'h0F, 8'h11, 2'b00);
        chk("mul1.busy_start", {31'b0, busy}, 32'd1);
        wait_done(nb, nt);
        chk("mul1.busy_cycles", nb, 32'd8);
        chk("mul1.latency", nt, 32'd8);
        chk("mul1.busy_end", {31'b0, busy}, 32'd0);

        // START on the DONE cycle is accepted
        tick();
        push("mul_03_05", 8'h0F, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 2'b10, 8'h03, 8'h05, 2'b00);
        wait_done(nb, nt);
        single("add_on_done", 1'b0, 2'b00, 8'h10, 8'h20, 2'b00, 8'h30, 1'b0, 1'b0, 1'b0);
        tick();

        // Multiply, full product, with an ADD request while BUSY that must be ignored
        push("mul_ff_ff", 8'h01, 8'hFE, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 2'b10, 8'hFF, 8'hFF, 2'b00);
        drive(1'b0, 2'b00, 8'h01, 8'h02, 2'b00);
        chk("ign.held_out", {24'b0, out}, 32'h30);
        wait_done(nb, nt);
        chk("ign.latency", nt, 32'd7);
        tick();
        tick();
        chk("ign.no_extra", sb.size(), 32'd0);

        // Reset during a multiply: outputs clear at once, no DONE
        push("mul_aborted", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 2'b10, 8'h12, 8'h34, 2'b00);
        tick();
        tick();
        tick();
        chk("abort.busy_before", {31'b0, busy}, 32'd1);
        chk("abort.hi_before", {24'b0, out_hi}, 32'hFE);
        rstn = 1'b0;
        #1;
        sb.delete();
        chk("abort.busy",  {31'b0, busy},   32'd0);
        chk("abort.done",  {31'b0, done},   32'd0);
        chk("abort.out",   {24'b0, out},    32'd0);
        chk("abort.hi",    {24'b0, out_hi}, 32'd0);
        chk("abort.zero",  {31'b0, zero},   32'd1);
        chk("abort.ovf",   {31'b0, ovf},    32'd0);
        tick();
        tick();
        rstn = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        chk("abort.no_done", {31'b0, done}, 32'd0);
        single("add_03_04", 1'b0, 2'b00, 8'h03, 8'h04, 2'b00, 8'h07, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("end.queue_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
